// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel arbitrating mux (round-robin or fixed priority) with a registered output and valid/ready handshakes
module arb_mux_n #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    parameter int MODE = 0,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_sel;
    logic [SELW-1:0]  r_ptr;
    logic             w_can_load;
    logic             w_found;
    logic             w_accept;
    logic [SELW-1:0]  w_gidx;
    logic [N-1:0]     w_grant;

    // Channel examined at scan position k: rotated by the pointer in round-robin, plain index in fixed priority
    function automatic logic [SELW-1:0] f_idx(input logic [SELW-1:0] ptr, input int k);
        int j;
        j = (MODE == 0) ? int'(ptr) + k : k;
        return SELW'((j >= N) ? j - N : j);
    endfunction

    assign w_can_load = !r_valid || out_ready;
    assign w_accept   = w_found && w_can_load;
    assign in_ready   = w_grant & {N{w_can_load}};
    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_sel    = r_sel;

    // Pick the first requesting channel in scan order; at most one grant bit is set
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_grant = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && in_valid[f_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_gidx  = f_idx(r_ptr, k);
                w_grant[f_idx(r_ptr, k)] = 1'b1;
            end
        end
    end

    // Output register and pointer: load on accept (even while draining), clear valid on a drain with no refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= in_data[w_gidx*WIDTH +: WIDTH];
            r_sel   <= w_gidx;
            if (MODE == 0) r_ptr <= (w_gidx == SELW'(N-1)) ? '0 : w_gidx + 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: table-driven scoreboard bench for arb_mux_n in round-robin and fixed-priority modes
module tb_arb_mux_n;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   iv0, iv1, rdy0, rdy1;
    logic [127:0] d0, d1;
    logic         ordy0, ordy1, ov0, ov1;
    logic [31:0]  od0, od1;
    logic [1:0]   os0, os1;
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  last_d0, last_d1;

    typedef struct packed {
        logic       m;
        logic [3:0] iv;
        logic       o;
        logic [3:0] r;
        logic       v;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    exp_t q[$];
    vec_t tbl[23];

    always #5 clk = ~clk;

    arb_mux_n #(.WIDTH(32), .N(4), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_data(d0), .in_ready(rdy0),
        .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy0)
    );

    arb_mux_n #(.WIDTH(32), .N(4), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_data(d1), .in_ready(rdy1),
        .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy1)
    );

    function automatic logic [31:0] mk(input int n, input int i);
        return 32'hA0 + 32'(i) + (32'(n) << 16);
    endfunction

    function automatic logic [127:0] pk(input int n);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = mk(n, i);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One cycle: drive at posedge+1, check in_ready at negedge, check outputs at next posedge+1
    task automatic step(input int n, input vec_t v);
        exp_t e;
        logic [3:0] rdy;
        if (v.m) begin
            iv1 = v.iv; ordy1 = v.o; d1 = pk(n);
        end else begin
            iv0 = v.iv; ordy0 = v.o; d0 = pk(n);
        end
        @(negedge clk);
        rdy = v.m ? rdy1 : rdy0;
        chk($sformatf("step%0d in_ready", n), 32'(rdy), 32'(v.r));
        if (v.r != 4'b0) begin
            e.s = 2'd0;
            for (int i = 0; i < 4; i++) if (v.r[i]) e.s = 2'(i);
            e.d = mk(n, int'(e.s));
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk($sformatf("step%0d out_valid", n), 32'(v.m ? ov1 : ov0), 32'(v.v));
        if (v.r != 4'b0) begin
            if (q.size() == 0) begin
                chk($sformatf("step%0d scoreboard empty", n), 32'd0, 32'd1);
            end else begin
                e = q.pop_front();
                chk($sformatf("step%0d out_data", n), v.m ? od1 : od0, e.d);
                chk($sformatf("step%0d out_sel", n), 32'(v.m ? os1 : os0), 32'(e.s));
                if (v.m) last_d1 = e.d; else last_d0 = e.d;
            end
        end else if (v.v) begin
            chk($sformatf("step%0d out_data stable", n), v.m ? od1 : od0, v.m ? last_d1 : last_d0);
        end
    endtask

    initial begin
        tbl = '{
            '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1},
            '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1},
            '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1},
            '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1},
            '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1},
            '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1},
            '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1},
            '{1'b0, 4'b0110, 1'b1, 4'b0010, 1'b1},
            '{1'b0, 4'b0110, 1'b1, 4'b0100, 1'b1},
            '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0},
            '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1},
            '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1},
            '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1},
            '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1},
            '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1},
            '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0},
            '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1},
            '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1},
            '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1},
            '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1},
            '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1},
            '{1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1},
            '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0}
        };
        last_d0 = '0;
        last_d1 = '0;
        iv0 = 4'b1111; ordy0 = 1'b1; d0 = pk(99);
        iv1 = 4'b1111; ordy1 = 1'b1; d1 = pk(99);
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(ov0), 32'd0);
        chk("reset out_data", od0, 32'd0);
        chk("reset out_sel", 32'(os0), 32'd0);
        chk("reset mode1 out_valid", 32'(ov1), 32'd0);
        iv0 = 4'b0000; iv1 = 4'b0000;
        rst = 1'b0;
        for (int n = 0; n < 23; n++) step(n, tbl[n]);
        chk("pre-reset out_valid", 32'(ov0), 32'd1);
        chk("pre-reset out_sel", 32'(os0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset out_valid", 32'(ov0), 32'd0);
        chk("async reset out_data", od0, 32'd0);
        chk("async reset out_sel", 32'(os0), 32'd0);
        iv0 = 4'b1111; ordy0 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(30, '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1});
        step(31, '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1});
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
